psc_trigger_framer: RTL

Multi-channel trigger-to-packet framer for the power-supply-controller (PSC) link. It edge-detects up to NUM_CH event-receiver trigger lines and timestamps each rising edge against a free-running 32-bit cycle counter. Pending triggers are arbitrated at packet boundaries, and each packet goes out as a 10-byte frame (SOP … CRC, EOP) on a valid/ready byte stream. That stream feeds the 8b/10b encoder and serializer stage, and idle frames fill the link whenever no trigger is pending.

---
 rtl/psc_trigger_framer.sv | 137 +++++++++++++
 1 files changed

// File: rtl/psc_trigger_framer.sv
// psc_trigger_framer: edge-detects trigger lines, timestamps them and frames them into SOP..CRC,EOP byte packets
// Ports: clk_i clock; reset_i async active-high reset; evr_trigger_i trigger lines;
//        tx_ready_i downstream ready; tx_valid_o/tx_byte_o/tx_is_k_o/tx_eop_o byte stream;
//        overflow_sticky_o set when any trigger was lost since reset.
module psc_trigger_framer #(
  parameter int         NUM_CH         = 4,
  parameter logic [7:0] TRIG_ADDR_BASE = 8'h70,
  parameter logic [7:0] IDLE_ADDR      = 8'h40,
  parameter logic [7:0] SOP            = 8'b001_11100,
  parameter logic [7:0] EOP            = 8'b101_11100,
  parameter bit         IDLE_ENABLE    = 1'b1
) (
  input  logic              clk_i,
  input  logic              reset_i,
  input  logic [NUM_CH-1:0] evr_trigger_i,
  input  logic              tx_ready_i,
  output logic              tx_valid_o,
  output logic [7:0]        tx_byte_o,
  output logic              tx_is_k_o,
  output logic              tx_eop_o,
  output logic              overflow_sticky_o
);
  localparam int SW = NUM_CH > 1 ? $clog2(NUM_CH) : 1;
  typedef enum logic {ST_SELECT, ST_SEND} state_e;
  state_e            state_q;
  logic [31:0]       cnt_q;
  logic [NUM_CH-1:0] prev_q, pend_q, ovf_q;
  logic [31:0]       ts_q [NUM_CH];
  logic [3:0]        idx_q;
  logic              f_ovf_q;
  logic [7:0]        f_addr_q;
  logic [31:0]       f_ts_q;
  logic [7:0]        crc_q;
  logic              tx_valid_q, tx_is_k_q, tx_eop_q, sticky_q;
  logic [7:0]        tx_byte_q;
  logic              any_pend;
  logic [SW-1:0]     sel;
  logic [NUM_CH-1:0] rise, clr;
  logic [3:0]        nidx;
  logic [4:0]        sh;
  logic [7:0]        crc_upd, nxt;
  function automatic logic [7:0] crc8(input logic [7:0] c, input logic [7:0] d);
    logic [7:0] r;
    r = c ^ d;
    for (int i = 0; i < 8; i++) r = r[7] ? {r[6:0], 1'b0} ^ 8'h07 : {r[6:0], 1'b0};
    return r;
  endfunction
  always_comb begin
    any_pend = |pend_q;
    sel = '0;
    for (int i = NUM_CH - 1; i >= 0; i--) if (pend_q[i]) sel = SW'(i);
    for (int i = 0; i < NUM_CH; i++) clr[i] = state_q == ST_SELECT && any_pend && sel == SW'(i);
    rise = evr_trigger_i & ~prev_q;
    nidx = idx_q + 4'd1;
    // bytes 4..7 walk the timestamp from its top byte down
    sh = {2'(3'd7 - nidx[2:0]), 3'b000};
    // running CRC including the byte being accepted, so byte 8 sees all of 1..7
    crc_upd = crc8(crc_q, tx_byte_q);
    nxt = nidx == 4'd1 ? {f_ovf_q, 7'b0} :
          nidx == 4'd2 ? f_addr_q :
          nidx == 4'd8 ? crc_upd :
          nidx == 4'd9 ? EOP :
          nidx >= 4'd4 ? f_ts_q[sh +: 8] : 8'h00;
  end
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q    <= ST_SELECT;
      cnt_q      <= '0;
      prev_q     <= '0;
      pend_q     <= '0;
      ovf_q      <= '0;
      for (int i = 0; i < NUM_CH; i++) ts_q[i] <= '0;
      idx_q      <= '0;
      f_ovf_q    <= 1'b0;
      f_addr_q   <= '0;
      f_ts_q     <= '0;
      crc_q      <= '0;
      tx_valid_q <= 1'b0;
      tx_byte_q  <= '0;
      tx_is_k_q  <= 1'b0;
      tx_eop_q   <= 1'b0;
      sticky_q   <= 1'b0;
    end else begin
      cnt_q  <= cnt_q + 32'd1;
      prev_q <= evr_trigger_i;
      // a rise on the channel being cleared this cycle re-arms it rather than overflowing
      for (int n = 0; n < NUM_CH; n++) begin
        if (rise[n]) begin
          if (pend_q[n] && !clr[n]) begin
            ovf_q[n] <= 1'b1;
            sticky_q <= 1'b1;
          end else begin
            pend_q[n] <= 1'b1;
            ovf_q[n]  <= 1'b0;
            ts_q[n]   <= cnt_q;
          end
        end else if (clr[n]) begin
          pend_q[n] <= 1'b0;
          ovf_q[n]  <= 1'b0;
        end
      end
      if (state_q == ST_SELECT) begin
        crc_q <= '0;
        idx_q <= '0;
        if (any_pend || IDLE_ENABLE) begin
          state_q    <= ST_SEND;
          tx_valid_q <= 1'b1;
          tx_byte_q  <= SOP;
          tx_is_k_q  <= 1'b1;
          tx_eop_q   <= 1'b0;
          f_ovf_q    <= any_pend & ovf_q[sel];
          f_addr_q   <= any_pend ? TRIG_ADDR_BASE + 8'(sel) : IDLE_ADDR;
          f_ts_q     <= any_pend ? ts_q[sel] : 32'h0;
        end
      end else if (tx_ready_i) begin
        if (idx_q >= 4'd1 && idx_q <= 4'd7) crc_q <= crc_upd;
        if (idx_q == 4'd9) begin
          state_q    <= ST_SELECT;
          tx_valid_q <= 1'b0;
          tx_byte_q  <= '0;
          tx_is_k_q  <= 1'b0;
          tx_eop_q   <= 1'b0;
        end else begin
          idx_q     <= nidx;
          tx_byte_q <= nxt;
          tx_is_k_q <= nidx == 4'd9;
          tx_eop_q  <= nidx == 4'd9;
        end
      end
    end
  end
  assign tx_valid_o        = tx_valid_q;
  assign tx_byte_o         = tx_byte_q;
  assign tx_is_k_o         = tx_is_k_q;
  assign tx_eop_o          = tx_eop_q;
  assign overflow_sticky_o = sticky_q;
endmodule
